// File: rtl/spi_flash_xip_reader.sv
// Wishbone classic read-only slave that turns each 32-bit read into an SPI
// READ (0x03) transaction against an EPCS-compatible flash (SPI mode 0).
module spi_flash_xip_reader #(
    parameter int unsigned ADDR_WIDTH     = 24,
    parameter int unsigned CLK_DIV        = 1,
    parameter int unsigned CS_HIGH_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    output logic [31:0]           wb_dat_o,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [3:0]            wb_sel_i,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  spi_sck_o,
    output logic                  spi_cs_n_o,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CSH_W = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
    localparam int unsigned BIT_W = 7;

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(64);
    localparam logic [BIT_W-1:0] DATA_BIT = BIT_W'(32);
    localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(CLK_DIV - 1);
    localparam logic [CSH_W-1:0] CSH_TC   = CSH_W'(CS_HIGH_CYCLES - 1);
    localparam logic [7:0]       CMD_READ = 8'h03;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        DESEL = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [CSH_W-1:0] csh_q, csh_d;
    logic [31:0]      tx_q, tx_d;
    logic [31:0]      rx_q, rx_d;
    logic [31:0]      dat_q, dat_d;
    logic             sck_q, sck_d;
    logic             cs_n_q, cs_n_d;
    logic             mosi_q, mosi_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    logic        req_c;
    logic        rd_req_c;
    logic        wr_req_c;
    logic        tick_c;
    logic        last_bit_c;
    logic [23:0] flash_adr_c;
    logic        sel_unused_c;

    assign req_c       = wb_cyc_i & wb_stb_i;
    assign rd_req_c    = req_c & ~wb_we_i;
    assign wr_req_c    = req_c & wb_we_i;
    assign last_bit_c  = (bit_q == LAST_BIT);
    assign tick_c      = (div_q == DIV_TC) & ~last_bit_c;
    assign flash_adr_c = 24'(wb_adr_i) & 24'hFFFFFC;
    assign sel_unused_c = ^wb_sel_i;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rd_req_c) state_d = SHIFT;
            end
            SHIFT: begin
                if (!req_c)          state_d = DESEL;
                else if (last_bit_c) state_d = DONE;
            end
            DONE: begin
                state_d = DESEL;
            end
            DESEL: begin
                if (csh_q == CSH_TC) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        div_d  = div_q;
        bit_d  = bit_q;
        csh_d  = csh_q;
        tx_d   = tx_q;
        rx_d   = rx_q;
        dat_d  = dat_q;
        sck_d  = sck_q;
        cs_n_d = cs_n_q;
        mosi_d = mosi_q;
        ack_d  = 1'b0;
        err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                sck_d  = 1'b0;
                mosi_d = 1'b0;
                csh_d  = '0;
                if (rd_req_c) begin
                    tx_d   = {CMD_READ, flash_adr_c};
                    bit_d  = '0;
                    div_d  = '0;
                    cs_n_d = 1'b0;
                    mosi_d = tx_d[31];
                end else if (wr_req_c) begin
                    // Guard keeps the error a single pulse if the master is slow to drop stb
                    err_d = ~err_q;
                end
            end
            SHIFT: begin
                if (!req_c) begin
                    cs_n_d = 1'b1;
                    sck_d  = 1'b0;
                    mosi_d = 1'b0;
                    csh_d  = '0;
                end else if (tick_c) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        if (bit_q >= DATA_BIT) rx_d = {rx_q[30:0], spi_miso_i};
                    end else begin
                        // Falling edge: advance so the next bit is stable before the rise
                        bit_d  = bit_q + BIT_W'(1);
                        tx_d   = {tx_q[30:0], 1'b0};
                        mosi_d = tx_q[30];
                    end
                end else if (!last_bit_c) begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            DONE: begin
                cs_n_d = 1'b1;
                sck_d  = 1'b0;
                mosi_d = 1'b0;
                ack_d  = 1'b1;
                csh_d  = '0;
                // First byte received (lowest address) lands in the low byte
                dat_d  = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
            end
            DESEL: begin
                cs_n_d = 1'b1;
                csh_d  = csh_q + CSH_W'(1);
            end
            default: begin
                cs_n_d = 1'b1;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            bit_q  <= '0;
            csh_q  <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
            dat_q  <= '0;
            sck_q  <= 1'b0;
            cs_n_q <= 1'b1;
            mosi_q <= 1'b0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            bit_q  <= bit_d;
            csh_q  <= csh_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            dat_q  <= dat_d;
            sck_q  <= sck_d;
            cs_n_q <= cs_n_d;
            mosi_q <= mosi_d;
            ack_q  <= ack_d;
            err_q  <= err_d;
        end
    end

    assign wb_dat_o   = dat_q;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign spi_sck_o  = sck_q;
    assign spi_cs_n_o = cs_n_q;
    assign spi_mosi_o = mosi_q;

endmodule
